// File: rtl/updown_counter_n.sv
// Loadable up/down counter over [0, max_val] with wrap or saturate at the boundary.
// count/ovf are registered (one edge); tc is combinational with zero latency.
module updown_counter_n #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic             at_bnd;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;

  // >= on the up side lets an out-of-range count (after load or max_val change) recover
  assign at_bnd = up ? (count >= max_val) : (count == '0);
  assign tc     = en & ~load & ~rst & at_bnd;

  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf & ~clr_ovf;
    if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      if (at_bnd) begin
        ovf_nxt = 1'b1;
        if (SATURATE) begin
          count_nxt = up ? max_val : '0;
        end else begin
          count_nxt = up ? '0 : max_val;
        end
      end else if (up) begin
        count_nxt = count + WIDTH'(1);
      end else begin
        count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RESET_VALUE;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: default wrap instance (WIDTH 3) and a saturating WIDTH 4 instance.
module tb_updown_counter_n;

  typedef struct {
    logic       rst, en, up, load, clr;
    logic [3:0] lv, mv;
    logic       tc;
    logic [3:0] cnt;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       d_rst = 1'b1, d_en = 1'b0, d_up = 1'b0, d_load = 1'b0, d_clr = 1'b0;
  logic [2:0] d_lv = '0, d_mv = 3'd7;
  logic [2:0] d_count;
  logic       d_tc, d_ovf;
  logic       s_rst = 1'b1, s_en = 1'b0, s_up = 1'b0, s_load = 1'b0, s_clr = 1'b0;
  logic [3:0] s_lv = '0, s_mv = 4'd9;
  logic [3:0] s_count;
  logic       s_tc, s_ovf;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  updown_counter_n dut_wrap (
    .clk(clk), .rst(d_rst), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
    .max_val(d_mv), .clr_ovf(d_clr), .count(d_count), .tc(d_tc), .ovf(d_ovf)
  );

  updown_counter_n #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .up(s_up), .load(s_load), .load_val(s_lv),
    .max_val(s_mv), .clr_ovf(s_clr), .count(s_count), .tc(s_tc), .ovf(s_ovf)
  );

  function automatic vec_t mk(input logic rst, en, up, load, input int lv, mv,
                              input logic clr, tc, input int cnt, input logic ovf);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.load = load; v.clr = clr;
    v.lv = 4'(lv); v.mv = 4'(mv); v.tc = tc; v.cnt = 4'(cnt); v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one vector, check tc before the edge, score count/ovf after it.
  task automatic apply(input vec_t x, input bit sat, input int idx);
    vec_t e;
    if (sat) begin
      s_rst = x.rst; s_en = x.en; s_up = x.up; s_load = x.load; s_clr = x.clr;
      s_lv = x.lv; s_mv = x.mv;
    end else begin
      d_rst = x.rst; d_en = x.en; d_up = x.up; d_load = x.load; d_clr = x.clr;
      d_lv = x.lv[2:0]; d_mv = x.mv[2:0];
    end
    #1;
    chk(sat ? "sat_tc" : "wrap_tc", idx, {3'b0, sat ? s_tc : d_tc}, {3'b0, x.tc});
    sb.push_back(x);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(sat ? "sat_count" : "wrap_count", idx, sat ? s_count : {1'b0, d_count}, e.cnt);
    chk(sat ? "sat_ovf" : "wrap_ovf", idx, {3'b0, sat ? s_ovf : d_ovf}, {3'b0, e.ovf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    // Defaults: ten reset cycles, then count down from 7 with wrap to max_val
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1,1,0,0,0,7,0, 0,7,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,6,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,5,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,4,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,3,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,2,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,1,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,0,0));
    tbl.push_back(mk(0,1,0,0,0,7,0, 1,7,1));
    tbl.push_back(mk(0,1,0,0,0,7,0, 0,6,1));
    // Up with max_val 4 from reset: 7 is out of range and wraps to 0
    tbl.push_back(mk(1,1,1,0,0,4,0, 0,7,0));
    tbl.push_back(mk(0,1,1,0,0,4,0, 1,0,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,1,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,2,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,3,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,4,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 1,0,1));
    // Load priority over en; reset over load; out-of-range load recovers
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,1,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,2,1));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,3,1));
    tbl.push_back(mk(0,1,1,1,6,4,0, 0,6,1));
    tbl.push_back(mk(1,1,1,1,2,4,0, 0,7,0));
    tbl.push_back(mk(0,0,0,1,5,4,0, 0,5,0));
    tbl.push_back(mk(0,1,1,0,0,4,0, 1,0,1));
    // Enable toggling and ovf clear (plain cycle clears, boundary cycle set wins)
    tbl.push_back(mk(0,0,1,0,0,4,0, 0,0,1));
    tbl.push_back(mk(0,1,1,0,0,4,1, 0,1,0));
    tbl.push_back(mk(0,0,1,0,0,4,0, 0,1,0));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,2,0));
    tbl.push_back(mk(0,0,1,0,0,4,0, 0,2,0));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,3,0));
    tbl.push_back(mk(0,0,1,0,0,4,0, 0,3,0));
    tbl.push_back(mk(0,1,1,0,0,4,0, 0,4,0));
    tbl.push_back(mk(0,0,1,0,0,4,0, 0,4,0));
    tbl.push_back(mk(0,1,1,0,0,4,1, 1,0,1));
    // max_val 0: boundary every cycle in both directions; reset mid-run
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,1,1,0,0,0,0, 1,0,1));
    tbl.push_back(mk(1,1,1,0,0,0,0, 0,7,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,1));
    tbl.push_back(mk(1,1,0,1,3,0,0, 0,7,0));
    foreach (tbl[i]) apply(tbl[i], 1'b0, i);

    // Saturating instance, max_val 9: climb, hold, descend, hold
    apply(mk(1,1,1,0,0,9,0, 0,15,0), 1'b1, 100);
    apply(mk(0,1,1,1,0,9,0, 0,0,0), 1'b1, 101);
    for (int i = 0; i < 9; i++) apply(mk(0,1,1,0,0,9,0, 0,i+1,0), 1'b1, 110 + i);
    for (int i = 0; i < 3; i++) apply(mk(0,1,1,0,0,9,0, 1,9,1), 1'b1, 120 + i);
    for (int i = 9; i > 0; i--) apply(mk(0,1,0,0,0,9,0, 0,i-1,1), 1'b1, 130 + i);
    for (int i = 0; i < 2; i++) apply(mk(0,1,0,0,0,9,0, 1,0,1), 1'b1, 140 + i);
    // Above-range value in saturate-up is forced to max_val
    apply(mk(0,1,1,1,12,9,0, 0,12,1), 1'b1, 150);
    apply(mk(0,1,1,0,0,9,0, 1,9,1), 1'b1, 151);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
